// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg: state encoding and default word width shared by the pattern_tx slice
package pattern_tx_pkg;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] SEND = 2'b01;
    localparam logic [1:0] GAP  = 2'b10;
    localparam int DW_DEF = 8;
endpackage

// File: rtl/pattern_tx_shreg.sv
// pattern_tx_shreg: captured pattern register plus down-counter selecting the bit driven next
module pattern_tx_shreg
    import pattern_tx_pkg::*;
#(
    parameter int DW = DW_DEF,
    localparam int LW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          reload,
    input  logic          shift,
    input  logic [DW-1:0] data,
    input  logic [LW-1:0] len,
    output logic          nxt_bit,
    output logic          last_bit
);
    logic [DW-1:0] sr_q, sr_d;
    logic [LW-1:0] cnt_q, cnt_d, len_q, len_d;

    // The pattern is held intact and indexed by the counter so a repeat can replay it.
    always_comb begin
        sr_d     = load ? data : sr_q;
        len_d    = load ? len : len_q;
        cnt_d    = load ? len : reload ? len_q : shift ? cnt_q - 1'b1 : cnt_q;
        nxt_bit  = sr_d[cnt_d];
        last_bit = cnt_q == '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= '0;
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: serial pattern transmitter (IDLE/SEND/GAP); PATTERN_TX_REPEAT_EN adds rpt for frame repeat
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int DW = DW_DEF,
    localparam int LW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] data,
    input  logic [LW-1:0] len,
`ifdef PATTERN_TX_REPEAT_EN
    input  logic          rpt,
`endif
    output logic          wo,
    output logic          wo_vld,
    output logic          busy,
    output logic          done
);
    logic [1:0] state_q, state_d;
    logic wo_q, wo_d, wo_vld_q, wo_vld_d, busy_q, busy_d, done_q, done_d;
    logic rpt_i, load, reload, shift, nxt_bit, last_bit;

`ifdef PATTERN_TX_REPEAT_EN
    assign rpt_i = rpt;
`else
    assign rpt_i = 1'b0;
`endif

    pattern_tx_shreg #(.DW(DW)) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .reload   (reload),
        .shift    (shift),
        .data     (data),
        .len      (len),
        .nxt_bit  (nxt_bit),
        .last_bit (last_bit)
    );

    // Outputs are computed from the next state so every output is a flop; bad encodings fall to IDLE.
    always_comb begin
        load     = state_q == IDLE && start;
        reload   = state_q == GAP && rpt_i;
        shift    = state_q == SEND && !last_bit;
        state_d  = (load || reload || shift) ? SEND : state_q == SEND ? GAP : IDLE;
        wo_d     = state_d == SEND && nxt_bit;
        wo_vld_d = state_d == SEND;
        busy_d   = state_d != IDLE;
        done_d   = state_d == GAP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wo_q     <= 1'b0;
            wo_vld_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wo_q     <= wo_d;
            wo_vld_q <= wo_vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign wo     = wo_q;
    assign wo_vld = wo_vld_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: table vectors, hand sequences and random traffic against a frame-queue model
module tb_pattern_tx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [7:0] data = '0;
    logic [2:0] len = '0;
    logic rpt = 1'b0;
    logic wo, wo_vld, busy, done;
    int checks = 0;
    int failures = 0;

`ifdef PATTERN_TX_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    pattern_tx dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .data   (data),
        .len    (len),
`ifdef PATTERN_TX_REPEAT_EN
        .rpt    (rpt),
`endif
        .wo     (wo),
        .wo_vld (wo_vld),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {logic wo; logic vld; logic busy; logic done;} o_t;
    typedef struct {logic [7:0] data; logic [2:0] len; logic [7:0] seq;} vec_t;

    o_t cur = '{1'b0, 1'b0, 1'b0, 1'b0};
    o_t q[$];
    logic [7:0] cap_d;
    logic [2:0] cap_l;
    vec_t tbl[5];

    task automatic check(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t act=%b exp=%b", n, $time, a, e);
        end
    endtask

    // A frame is len+1 data bits MSB-first followed by one done/gap cycle.
    task automatic push_frame();
        for (int i = int'(cap_l); i >= 0; i--) q.push_back('{cap_d[i], 1'b1, 1'b1, 1'b0});
        q.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
    endtask

    task automatic tick();
        @(posedge clk);
        if (!cur.busy && start) begin
            cap_d = data;
            cap_l = len;
            push_frame();
        end else if (cur.done && REP && rpt) begin
            push_frame();
        end
        cur = (q.size() != 0) ? q.pop_front() : '{1'b0, 1'b0, 1'b0, 1'b0};
        #1;
        check("model_wo", wo, cur.wo);
        check("model_vld", wo_vld, cur.vld);
        check("model_busy", busy, cur.busy);
        check("model_done", done, cur.done);
    endtask

    initial begin
        tbl[0] = '{8'b1011_0110, 3'd7, 8'b1011_0110};
        tbl[1] = '{8'h03, 3'd1, 8'b1100_0000};
        tbl[2] = '{8'h01, 3'd0, 8'b1000_0000};
        tbl[3] = '{8'hA5, 3'd3, 8'b0101_0000};
        tbl[4] = '{8'hF0, 3'd5, 8'b1100_0000};

        #1;
        check("rst_wo", wo, 1'b0);
        check("rst_vld", wo_vld, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        foreach (tbl[v]) begin
            start = 1'b1;
            data = tbl[v].data;
            len = tbl[v].len;
            tick();
            start = 1'b0;
            for (int k = 0; k <= int'(tbl[v].len); k++) begin
                if (k != 0) tick();
                check("tbl_wo", wo, tbl[v].seq[7-k]);
                check("tbl_vld", wo_vld, 1'b1);
            end
            tick();
            check("tbl_gap_done", done, 1'b1);
            check("tbl_gap_vld", wo_vld, 1'b0);
            check("tbl_gap_busy", busy, 1'b1);
            tick();
            check("tbl_idle_busy", busy, 1'b0);
            check("tbl_idle_done", done, 1'b0);
        end

        start = 1'b1;
        data = 8'h0A;
        len = 3'd3;
        tick();
        data = 8'h00;
        len = 3'd7;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) tick();
            check("busy_start_wo", wo, k[0] ? 1'b0 : 1'b1);
        end
        tick();
        check("busy_start_gap", done, 1'b1);
        tick();
        check("busy_start_idle", busy, 1'b0);
        tick();
        check("restart_in_idle", busy, 1'b1);
        start = 1'b0;
        repeat (10) tick();

        start = 1'b1;
        data = 8'hFF;
        len = 3'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 reset = 1'b0;
        q.delete();
        cur = '{1'b0, 1'b0, 1'b0, 1'b0};
        #1;
        check("async_rst_wo", wo, 1'b0);
        check("async_rst_vld", wo_vld, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        @(posedge clk);
        #1;
        check("held_rst_done", done, 1'b0);
        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("post_rst_done", done, 1'b1);
        tick();

        if (REP) begin
            rpt = 1'b1;
            start = 1'b1;
            data = 8'h05;
            len = 3'd2;
            tick();
            start = 1'b0;
            for (int f = 0; f < 3; f++) begin
                for (int b = 0; b < 3; b++) begin
                    if (f != 0 || b != 0) tick();
                    check("rpt_wo", wo, b != 1);
                end
                if (f == 2) rpt = 1'b0;
                tick();
                check("rpt_done", done, 1'b1);
            end
            tick();
            check("rpt_stop_idle", busy, 1'b0);
        end

        for (int c = 0; c < 400; c++) begin
            start = $urandom_range(0, 3) == 0;
            data = 8'($urandom);
            len = 3'($urandom);
            rpt = REP && ($urandom_range(0, 3) != 0);
            tick();
        end
        start = 1'b0;
        rpt = 1'b0;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter DW, default 8, width of the pattern data word.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to transmit one frame; sampled on rising clk.
REQ-005 data  input  DW  pattern bits; captured on accepted start.
REQ-006 len  input  $clog2(DW)  frame length minus 1 (bits sent = len+1); captured on accepted start.
REQ-007 wo  output  1  serial bit stream; drives a serial detector's wi input.
REQ-008 wo_vld  output  1  high while wo carries a pattern bit.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  single-cycle pulse marking frame completion.

Function
REQ-011 The FSM SHALL have three states: IDLE, SEND, GAP.
REQ-012 IDLE->SEND on start=1; data and len are captured into the shift register and bit counter in the same edge.
REQ-013 Latency: start sampled at edge N, so the first bit appears on wo after edge N, i.e. during cycle N+1.
REQ-014 Bit order: data[len] first, down to data[0], one bit per clk, MSB-first within the captured length.
REQ-015 SEND->GAP on the edge after bit data[0] has been driven for one cycle; the counter reaching 0 ends the frame.
REQ-016 GAP lasts exactly one cycle with wo=0 and wo_vld=0, which forces the downstream detector back to its idle state; done=1 in this cycle only.
REQ-017 GAP->IDLE unconditionally (except in repeat mode, see REQ-023).
REQ-018 start asserted in SEND or GAP SHALL be ignored; there is no queueing, and data and len changes while busy have no effect.
REQ-019 In IDLE: wo=0, wo_vld=0, done=0.
REQ-020 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-021 Undefined state encoding SHALL recover to IDLE on the next edge with all outputs low.

Reset
REQ-022 reset=0 SHALL immediately force IDLE and set wo=0, wo_vld=0, busy=0, done=0, with the shift register and counter cleared; a reset mid-frame abandons the frame without a done pulse.

Configuration
REQ-023 With macro PATTERN_TX_REPEAT_EN defined, the block adds input port rpt (1 bit).
- If rpt=1 in the GAP cycle, the next state is SEND, reloading the captured pattern and len; done still pulses once per frame.
- rpt=0 in GAP returns the block to IDLE.
REQ-024 Without PATTERN_TX_REPEAT_EN, the rpt port does not exist and GAP always goes to IDLE.

Structure
REQ-025 Shared package pattern_tx_pkg SHALL hold the state encoding (IDLE=2'b00, SEND=2'b01, GAP=2'b10) and the DW default constant.
REQ-026 One sub-module pattern_tx_shreg SHALL hold the DW-bit load/shift register and the down-counter, exposing last_bit; the FSM stays in pattern_tx.

Verification
REQ-027 reset=0 mid-frame (data=8'hFF, len=7, after 3 bits) -> wo=0, wo_vld=0, busy=0 immediately; no done pulse; next start sends a full new frame.
REQ-028 start=1 with data=8'b1011_0110, len=7 -> wo over cycles N+1..N+8 = 1,0,1,1,0,1,1,0 with wo_vld=1; cycle N+9 wo=0, wo_vld=0, done=1; busy=0 from N+10.
REQ-029 data=8'h03, len=1 -> wo=1,1 for two cycles, then GAP; a connected fsm_basic-style detector reaches its S1 state and then returns to IDLE.
REQ-030 len=0, data=8'h01 -> a single bit 1, then GAP with done pulsed; the frame occupies 2 busy cycles in total.
REQ-031 start re-asserted every cycle during a len=3 frame with data changed to 8'h00 -> the original frame is unaffected; the next frame starts only on start sampled in IDLE.
REQ-032 PATTERN_TX_REPEAT_EN, rpt=1, data=8'h05, len=2 -> repeating 1,0,1,gap with done pulsing every 4 cycles; dropping rpt before a GAP causes that GAP to return to IDLE.
